// File: rtl/robot_tracker_if.sv
// Command/status bundle between the upstream robot controller and the tracker.
// master: drives the en/front/rotate commands; slave: the tracker, returns pose and counters.
interface robot_tracker_if #(
  parameter int unsigned W = 4
) ();

  logic         en;
  logic         front;
  logic         rotate;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [1:0]   heading;
  logic [15:0]  steps;
  logic [15:0]  turns;
  logic         at_home;
  logic         err;
  logic         bump;

  modport master (
    output en, front, rotate,
    input  x, y, heading, steps, turns, at_home, err, bump
  );

  modport slave (
    input  en, front, rotate,
    output x, y, heading, steps, turns, at_home, err, bump
  );

endinterface

// File: rtl/robot_tracker.sv
// Grid position/heading tracker for a robot driven by front/rotate commands.
// Optional macro TRACKER_BOUNDS_EN: block moves that leave the 0..2^W-1 grid and pulse bump;
// when undefined, coordinates wrap modulo 2^W and bump stays 0.
module robot_tracker #(
  parameter int unsigned W      = 4,
  parameter int unsigned HOME_X = 0,
  parameter int unsigned HOME_Y = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  robot_tracker_if.slave    bus_io
);

  localparam logic [W-1:0] HomeX = W'(HOME_X);
  localparam logic [W-1:0] HomeY = W'(HOME_Y);

  typedef enum logic [1:0] {
    HdN = 2'd0,
    HdE = 2'd1,
    HdS = 2'd2,
    HdW = 2'd3
  } heading_e;

  heading_e     heading_q, heading_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [15:0]  steps_q, turns_q;
  logic         err_q, bump_q;
  logic         blocked;

  // Candidate position for a forward move, next clockwise heading, and edge-of-grid check.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    heading_d = HdN;
    blocked   = 1'b0;
    unique case (heading_q)
      HdN: begin
        y_d       = y_q + W'(1);
        heading_d = HdE;
`ifdef TRACKER_BOUNDS_EN
        blocked   = (y_q == '1);
`endif
      end
      HdE: begin
        x_d       = x_q + W'(1);
        heading_d = HdS;
`ifdef TRACKER_BOUNDS_EN
        blocked   = (x_q == '1);
`endif
      end
      HdS: begin
        y_d       = y_q - W'(1);
        heading_d = HdW;
`ifdef TRACKER_BOUNDS_EN
        blocked   = (y_q == '0);
`endif
      end
      HdW: begin
        x_d       = x_q - W'(1);
        heading_d = HdN;
`ifdef TRACKER_BOUNDS_EN
        blocked   = (x_q == '0);
`endif
      end
      default: ;
    endcase
  end

  // Heading FSM plus pose/counter registers; front+rotate together is illegal and does nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heading_q <= HdN;
      x_q       <= HomeX;
      y_q       <= HomeY;
      steps_q   <= '0;
      turns_q   <= '0;
      err_q     <= 1'b0;
      bump_q    <= 1'b0;
    end else begin
      bump_q <= 1'b0;
      if (bus_io.en) begin
        if (bus_io.front && bus_io.rotate) begin
          err_q <= 1'b1;
        end else if (bus_io.rotate) begin
          heading_q <= heading_d;
          if (turns_q != 16'hFFFF) turns_q <= turns_q + 16'd1;
        end else if (bus_io.front) begin
          if (blocked) begin
            bump_q <= 1'b1;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
          end
        end
      end
    end
  end

  assign bus_io.x       = x_q;
  assign bus_io.y       = y_q;
  assign bus_io.heading = heading_q;
  assign bus_io.steps   = steps_q;
  assign bus_io.turns   = turns_q;
  assign bus_io.err     = err_q;
  assign bus_io.bump    = bump_q;
  assign bus_io.at_home = (x_q == HomeX) && (y_q == HomeY);

endmodule

// File: tb/tb_robot_tracker.sv
// Directed bench for robot_tracker: a vector table for the main command walk plus
// hand-written sequences for illegal commands, grid edge, en hold and async reset.
module tb_robot_tracker;

  localparam int unsigned W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  robot_tracker_if #(.W(W)) bus ();

  robot_tracker #(
    .W      (W),
    .HOME_X (0),
    .HOME_Y (0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         en;
    logic         front;
    logic         rotate;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   hd;
    logic [15:0]  steps;
    logic [15:0]  turns;
    logic         home;
    logic         err;
    logic         bump;
  } vec_t;

  function automatic vec_t mk(input bit e, input bit f, input bit r, input int x, input int y,
                              input int h, input int s, input int t, input bit ho, input bit er,
                              input bit bu);
    vec_t v;
    v.en = e; v.front = f; v.rotate = r;
    v.x = W'(x); v.y = W'(y); v.hd = 2'(h);
    v.steps = 16'(s); v.turns = 16'(t);
    v.home = ho; v.err = er; v.bump = bu;
    return v;
  endfunction

  task automatic check(input string name, input int x, input int y, input int h, input int s,
                       input int t, input bit ho, input bit er, input bit bu);
    logic [2*W+36:0] got, exp;
    got = {bus.x, bus.y, bus.heading, bus.steps, bus.turns, bus.at_home, bus.err, bus.bump};
    exp = {W'(x), W'(y), 2'(h), 16'(s), 16'(t), ho, er, bu};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d hd=%0d steps=%0d turns=%0d home=%b err=%b bump=%b | want x=%0d y=%0d hd=%0d steps=%0d turns=%0d home=%b err=%b bump=%b",
               name, bus.x, bus.y, bus.heading, bus.steps, bus.turns, bus.at_home, bus.err,
               bus.bump, x, y, h, s, t, ho, er, bu);
    end
  endtask

  // Drive a command at the falling edge, let one rising edge sample it, then settle.
  task automatic step(input bit e, input bit f, input bit r);
    @(negedge clk);
    bus.en = e; bus.front = f; bus.rotate = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.front = 1'b0; bus.rotate = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  vec_t tbl[17];

  initial begin
    bus.en = 1'b0; bus.front = 1'b0; bus.rotate = 1'b0;

    //             en f  r  x  y  hd st tu ho er bu
    tbl[0]  = mk(1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 2, 0, 2, 1, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 0, 3, 0, 3, 1, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 1, 0, 1, 4, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 2, 0, 2, 4, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 3, 0, 3, 4, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 3, 0, 3, 4, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 3, 1, 3, 5, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 3, 2, 3, 6, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 2, 2, 4, 6, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 1, 2, 5, 6, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 2, 6, 6, 1, 0, 0);
    tbl[13] = mk(1, 0, 1, 0, 0, 3, 6, 7, 1, 0, 0);
`ifdef TRACKER_BOUNDS_EN
    tbl[14] = mk(1, 1, 0, 0, 0, 3, 6, 7, 1, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 3, 6, 7, 1, 0, 0);
    tbl[16] = mk(1, 0, 1, 0, 0, 0, 6, 8, 1, 0, 0);
`else
    tbl[14] = mk(1, 1, 0, 15, 0, 3, 7, 7, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 15, 0, 3, 7, 7, 0, 0, 0);
    tbl[16] = mk(1, 0, 1, 15, 0, 0, 7, 8, 0, 0, 0);
`endif

    #1;
    do_reset();
    check("reset_state", 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].en, tbl[i].front, tbl[i].rotate);
      check($sformatf("vec%0d", i), int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].hd),
            int'(tbl[i].steps), int'(tbl[i].turns), tbl[i].home, tbl[i].err, tbl[i].bump);
    end

    // Illegal front+rotate: sticky err, no motion; legal commands still execute.
    do_reset();
    step(1, 1, 1);
    check("illegal_cmd", 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    step(1, 1, 0);
    check("after_illegal_front", 0, 1, 0, 1, 0, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1);
    check("after_illegal_rotate", 0, 1, 1, 1, 1, 1'b0, 1'b1, 1'b0);

    // Face west at x=0 and try to move off the grid.
    do_reset();
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    check("face_west", 0, 0, 3, 0, 3, 1'b1, 1'b0, 1'b0);
    step(1, 1, 0);
`ifdef TRACKER_BOUNDS_EN
    check("west_edge", 0, 0, 3, 0, 3, 1'b1, 1'b0, 1'b1);
    step(1, 0, 0);
    check("bump_one_cycle", 0, 0, 3, 0, 3, 1'b1, 1'b0, 1'b0);
`else
    check("west_wrap", 15, 0, 3, 1, 3, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0);
    check("after_wrap_idle", 15, 0, 3, 1, 3, 1'b0, 1'b0, 1'b0);
`endif

    // en low freezes everything even with front held.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
`ifdef TRACKER_BOUNDS_EN
      check($sformatf("en_hold%0d", i), 0, 0, 3, 0, 3, 1'b1, 1'b0, 1'b0);
`else
      check($sformatf("en_hold%0d", i), 15, 0, 3, 1, 3, 1'b0, 1'b0, 1'b0);
`endif
    end

    step(1, 0, 1);
    step(1, 1, 0);
`ifdef TRACKER_BOUNDS_EN
    check("pre_reset_move", 0, 1, 0, 1, 4, 1'b0, 1'b0, 1'b0);
`else
    check("pre_reset_move", 15, 1, 0, 2, 4, 1'b0, 1'b0, 1'b0);
`endif

    // Async reset between edges, with a front command in flight.
    @(negedge clk);
    bus.en = 1'b1; bus.front = 1'b1; bus.rotate = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_now", 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_held_over_edge", 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("reset_released", 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first_cmd_after_reset", 0, 1, 0, 1, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/robot_tracker.md
ROBOT_TRACKER -- requirements
Module: robot_tracker

Interface
REQ-001 SHALL have parameter W, default 4: width of each grid coordinate.
REQ-002 SHALL have parameter HOME_X, default 0: start/home column.
REQ-003 SHALL have parameter HOME_Y, default 0: start/home row.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  qualifies front/rotate for the current cycle.
REQ-007 SHALL have port front  input  1  move-forward command from the upstream Mealy robot controller.
REQ-008 SHALL have port rotate  input  1  rotate command from the upstream Mealy robot controller.
REQ-009 SHALL have port x  output  W  current column.
REQ-010 SHALL have port y  output  W  current row.
REQ-011 SHALL have port heading  output  2  current facing: 0=N, 1=E, 2=S, 3=W.
REQ-012 SHALL have port steps  output  16  count of executed forward moves.
REQ-013 SHALL have port turns  output  16  count of executed rotations.
REQ-014 SHALL have port at_home  output  1  high when x==HOME_X and y==HOME_Y.
REQ-015 SHALL have port err  output  1  sticky illegal-command flag.
REQ-016 SHALL have port bump  output  1  one-cycle blocked-move pulse (see Configuration).

Function
REQ-017 Heading FSM SHALL have four states N, E, S, W; a rotate command SHALL advance clockwise: N->E->S->W->N.
REQ-018 A front command SHALL update the position by heading: N y+1, E x+1, S y-1, W x-1; heading unchanged.
REQ-019 Commands SHALL be sampled only on rising clk edges with en=1; en=0 SHALL hold all state and clear bump.
REQ-020 Latency SHALL be one cycle: a command sampled at edge k SHALL be visible on the outputs after edge k.
REQ-021 front=0 and rotate=0 with en=1 SHALL hold position, heading and counters.
REQ-022 front=1 and rotate=1 with en=1 SHALL set err and perform neither a move nor a rotation; err SHALL stay 1 until reset.
REQ-023 steps SHALL increment by 1 per executed move; turns SHALL increment by 1 per executed rotation; both SHALL saturate at 16'hFFFF.
REQ-024 at_home SHALL be decoded combinationally from the registered x and y, with no added latency.
REQ-025 All outputs except at_home SHALL be driven directly from registers.

Reset
REQ-026 rst_n=0 SHALL immediately force x=HOME_X, y=HOME_Y, heading=N, steps=0, turns=0, err=0 and bump=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight command.
REQ-028 The first command SHALL be sampled on the first rising clk edge after rst_n rises.

Configuration
REQ-029 Macro TRACKER_BOUNDS_EN defined: a front move that would take x or y below 0 or above 2^W-1 SHALL be blocked.
REQ-030 For a blocked move, position and steps SHALL be unchanged and bump SHALL pulse high for exactly one cycle.
REQ-031 Macro TRACKER_BOUNDS_EN undefined: coordinates SHALL wrap modulo 2^W, and bump SHALL be tied to 0.

Verification
REQ-032 Reset, then en=1 rotate x4 -> heading sequence 1,2,3,0; turns=4; x=0, y=0; at_home=1.
REQ-033 From reset, front x3 (heading N) -> y=3, x=0, steps=3, at_home=0; then rotate x2 and front x3 -> y=0, at_home=1, steps=6, turns=2.
REQ-034 front=1 and rotate=1 for one cycle -> err=1, no state change; later legal commands execute normally and err stays 1.
REQ-035 From reset, rotate x3 (heading W), then front -> with TRACKER_BOUNDS_EN: x=0, steps=0, bump=1 for one cycle; without the macro: x=15 (W=4), steps=1, bump=0.
REQ-036 Hold en=0 for 5 cycles with front=1 -> no change; pulse rst_n low between clk edges after some moves -> all outputs return to reset values immediately.
